vmem_arbiter: RTL and testbench

- Single-port SRAM access sequencer shared by two requesters: the display fetch path (read, latency-critical) and the SPI command write path (write, best-effort).
- Owns all SRAM strobes and enforces fixed read/write cycle timing.
- Prioritises display reads; a starvation counter bounds write wait.
- Sits between the pixel fetch/vbuffer feed and the vcmd write path, clocked by the memory clock.

---
 rtl/vmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_vmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_arbiter.sv
// Single-port SRAM sequencer arbitrating display reads against SPI command writes.
// Optional write-wait statistics are built when VMEM_ARB_STATS_EN is defined.
module vmem_arbiter #(
  parameter int AWIDTH     = 19,
  parameter int DWIDTH     = 8,
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              MemClk,
  input  logic              MemRst,
  input  logic              DispReq,
  input  logic [AWIDTH-1:0] DispAddr,
  output logic              DispGnt,
  output logic [DWIDTH-1:0] DispData,
  output logic              DispValid,
  input  logic              WrReq,
  input  logic [AWIDTH-1:0] WrAddr,
  input  logic [DWIDTH-1:0] WrData,
  output logic              WrGnt,
  output logic              WrDone,
  output logic [AWIDTH-1:0] MemAddrPort,
  output logic [DWIDTH-1:0] MemDataOut,
  input  logic [DWIDTH-1:0] MemDataIn,
  output logic              MemDataDrive,
  output logic              MemWriteEnable,
  output logic              MemOutputEnable,
  output logic              Busy,
  output logic [7:0]        WaitMax
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int SW      = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] starve, starve_n;
  logic          rd_win, wr_win;
  logic          rd_last;

  assign rd_last = (state == RD) && (cnt == CW'(RD_CYCLES - 1));

  // Arbitration and sequencing; writes only beat a pending read once starved.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_win  = 1'b0;
    wr_win  = 1'b0;
    case (state)
      IDLE: begin
        if (WrReq && (!DispReq || (starve >= SW'(STARVE_MAX)))) begin
          wr_win  = 1'b1;
          state_n = WR_SETUP;
          cnt_n   = '0;
        end else if (DispReq) begin
          rd_win  = 1'b1;
          state_n = RD;
          cnt_n   = '0;
        end
      end
      RD: begin
        if (cnt == CW'(RD_CYCLES - 1)) state_n = IDLE;
        else                           cnt_n   = cnt + CW'(1);
      end
      WR_SETUP: state_n = WR_PULSE;
      WR_PULSE: begin
        if (cnt == CW'(WR_CYCLES - 1)) state_n = WR_HOLD;
        else                           cnt_n   = cnt + CW'(1);
      end
      WR_HOLD: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    starve_n = starve;
    if (!WrReq || wr_win)
      starve_n = '0;
    else if (rd_win && (starve < SW'(STARVE_MAX)))
      starve_n = starve + SW'(1);
  end

  assign DispGnt = rd_win;
  assign WrGnt   = wr_win;

  always_ff @(posedge MemClk or posedge MemRst) begin
    if (MemRst) begin
      state  <= IDLE;
      cnt    <= '0;
      starve <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      starve <= starve_n;
    end
  end

  // Strobes are registered from the next state so the SRAM pins never glitch.
  always_ff @(posedge MemClk or posedge MemRst) begin
    if (MemRst) begin
      MemOutputEnable <= 1'b1;
      MemWriteEnable  <= 1'b1;
      MemDataDrive    <= 1'b0;
      WrDone          <= 1'b0;
      Busy            <= 1'b0;
      DispValid       <= 1'b0;
      DispData        <= '0;
      MemAddrPort     <= '0;
      MemDataOut      <= '0;
    end else begin
      MemOutputEnable <= (state_n != RD);
      MemWriteEnable  <= (state_n != WR_PULSE);
      MemDataDrive    <= (state_n == WR_SETUP) || (state_n == WR_PULSE) ||
                         (state_n == WR_HOLD);
      WrDone          <= (state_n == WR_HOLD);
      Busy            <= (state_n != IDLE);
      DispValid       <= rd_last;
      if (rd_last)
        DispData <= MemDataIn;
      if (wr_win) begin
        MemAddrPort <= WrAddr;
        MemDataOut  <= WrData;
      end else if (rd_win) begin
        MemAddrPort <= DispAddr;
      end
    end
  end

`ifdef VMEM_ARB_STATS_EN
  logic [7:0] wait_cnt;

  // The wait count is sampled into the running maximum at the moment of grant.
  always_ff @(posedge MemClk or posedge MemRst) begin
    if (MemRst) begin
      wait_cnt <= '0;
      WaitMax  <= '0;
    end else if (wr_win) begin
      wait_cnt <= '0;
      if (wait_cnt > WaitMax)
        WaitMax <= wait_cnt;
    end else if (WrReq && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign WaitMax = '0;
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench for vmem_arbiter: directed scenarios then random traffic,
// all compared against a transaction-timing model of the arbiter.
module tb_vmem_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int RD = 2;
  localparam int WR = 2;
  localparam int SM = 4;
`ifdef VMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          MemClk, MemRst;
  logic          DispReq, DispGnt, DispValid;
  logic [AW-1:0] DispAddr;
  logic [DW-1:0] DispData;
  logic          WrReq, WrGnt, WrDone;
  logic [AW-1:0] WrAddr;
  logic [DW-1:0] WrData;
  logic [AW-1:0] MemAddrPort;
  logic [DW-1:0] MemDataOut, MemDataIn;
  logic          MemDataDrive, MemWriteEnable, MemOutputEnable, Busy;
  logic [7:0]    WaitMax;

  vmem_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .RD_CYCLES(RD), .WR_CYCLES(WR), .STARVE_MAX(SM)
  ) dut (
    .MemClk(MemClk), .MemRst(MemRst),
    .DispReq(DispReq), .DispAddr(DispAddr), .DispGnt(DispGnt),
    .DispData(DispData), .DispValid(DispValid),
    .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData),
    .WrGnt(WrGnt), .WrDone(WrDone),
    .MemAddrPort(MemAddrPort), .MemDataOut(MemDataOut), .MemDataIn(MemDataIn),
    .MemDataDrive(MemDataDrive), .MemWriteEnable(MemWriteEnable),
    .MemOutputEnable(MemOutputEnable), .Busy(Busy), .WaitMax(WaitMax)
  );

  initial begin
    MemClk = 1'b0;
    forever #5 MemClk = ~MemClk;
  end

  int passed, total, cyc;

  // Transaction model: grant times plus fixed access lengths give every strobe window.
  int          free_at, rd_t, wr_t, starve, wait_cnt, wait_max;
  logic [AW-1:0] rd_addr_m, wr_addr_m;
  logic [DW-1:0] rd_data_m, wr_data_m;
  bit          m_dg, m_wg;
  logic        obs_dg, obs_wg;
  logic [DW-1:0] sram    [logic [AW-1:0]];
  logic [DW-1:0] exp_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] defaultByte(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] sramRead(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : defaultByte(a);
  endfunction

  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : defaultByte(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic modelReset();
    free_at  = cyc;
    rd_t     = -100;
    wr_t     = -100;
    starve   = 0;
    wait_cnt = 0;
    wait_max = 0;
  endtask

  task automatic checkReset();
    checkOutput("rst_we_n",   MemWriteEnable, 1);
    checkOutput("rst_oe_n",   MemOutputEnable, 1);
    checkOutput("rst_drive",  MemDataDrive, 0);
    checkOutput("rst_addr",   MemAddrPort, 0);
    checkOutput("rst_dout",   MemDataOut, 0);
    checkOutput("rst_dgnt",   DispGnt, 0);
    checkOutput("rst_wgnt",   WrGnt, 0);
    checkOutput("rst_valid",  DispValid, 0);
    checkOutput("rst_done",   WrDone, 0);
    checkOutput("rst_busy",   Busy, 0);
    checkOutput("rst_ddata",  DispData, 0);
    checkOutput("rst_waitmx", WaitMax, 0);
  endtask

  task automatic resetDut();
    MemRst  = 1'b1;
    DispReq = 1'b0;
    WrReq   = 1'b0;
    #2;
    checkReset();
    @(posedge MemClk);
    #1;
    MemRst = 1'b0;
    modelReset();
  endtask

  // Called at posedge+1; drives one cycle, checks at the falling edge, returns at next posedge+1.
  task automatic applyStimulus(input logic dr, input logic [AW-1:0] da, input logic wr,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit idle, rd_win, wr_win;
    DispReq  = dr;
    DispAddr = da;
    WrReq    = wr;
    WrAddr   = wa;
    WrData   = wd;
    #4;
    idle   = (cyc >= free_at);
    m_wg   = idle && wr && (!dr || starve >= SM);
    m_dg   = idle && !m_wg && dr;
    rd_win = (cyc >= rd_t + 1) && (cyc <= rd_t + RD);
    wr_win = (cyc >= wr_t + 1) && (cyc <= wr_t + WR + 2);
    obs_dg = DispGnt;
    obs_wg = WrGnt;
    checkOutput("disp_gnt",   DispGnt, m_dg);
    checkOutput("wr_gnt",     WrGnt, m_wg);
    checkOutput("busy",       Busy, !idle);
    checkOutput("oe_n",       MemOutputEnable, !rd_win);
    checkOutput("we_n",       MemWriteEnable, !((cyc >= wr_t + 2) && (cyc <= wr_t + WR + 1)));
    checkOutput("drive",      MemDataDrive, wr_win);
    checkOutput("wr_done",    WrDone, cyc == wr_t + WR + 2);
    checkOutput("disp_valid", DispValid, cyc == rd_t + RD + 1);
    checkOutput("wait_max",   WaitMax, STATS ? wait_max : 0);
    if (cyc == rd_t + RD + 1) checkOutput("disp_data", DispData, rd_data_m);
    if (rd_win) checkOutput("rd_addr", MemAddrPort, rd_addr_m);
    if (wr_win) begin
      checkOutput("wr_addr", MemAddrPort, wr_addr_m);
      checkOutput("wr_data", MemDataOut, wr_data_m);
    end
    if (MemWriteEnable === 1'b0) sram[MemAddrPort] = MemDataOut;
    MemDataIn = (MemOutputEnable === 1'b0) ? sramRead(MemAddrPort) : 8'hEE;
    if (cyc == wr_t + WR + 2) exp_mem[wr_addr_m] = wr_data_m;
    if (m_wg) begin
      wr_t = cyc; free_at = cyc + WR + 3; wr_addr_m = wa; wr_data_m = wd;
    end
    if (m_dg) begin
      rd_t = cyc; free_at = cyc + RD + 1; rd_addr_m = da; rd_data_m = modelRead(da);
    end
    if (!wr || m_wg) starve = 0;
    else if (m_dg && starve < SM) starve++;
    if (m_wg) begin
      if (wait_cnt > wait_max) wait_max = wait_cnt;
      wait_cnt = 0;
    end else if (wr && wait_cnt < 255) begin
      wait_cnt++;
    end
    cyc++;
    @(posedge MemClk);
    #1;
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, '0);
  endtask

  task automatic drainModel();
    for (int i = 0; i < 10 && cyc < free_at + 2; i++) applyStimulus(0, '0, 0, '0, '0);
  endtask

  initial begin
    int          nd, wait_i;
    bit          w_seen, d_seen;
    logic [0:18] dr_pat, wr_pat;
    logic        dr_lvl, wr_lvl;
    logic [AW-1:0] da, wa;
    logic [DW-1:0] wd;

    passed = 0; total = 0; cyc = 0;
    MemRst = 1'b1; DispReq = 0; WrReq = 0; DispAddr = '0; WrAddr = '0; WrData = '0;
    MemDataIn = 8'hEE;
    sram[19'h00005]    = 8'h2A;
    exp_mem[19'h00005] = 8'h2A;
    #1;
    checkReset();
    @(posedge MemClk);
    #1;
    resetDut();

    $display("[TB] single read");
    applyStimulus(1, 19'h00005, 0, '0, '0);
    idleSteps(4);

    $display("[TB] single write");
    applyStimulus(0, '0, 1, 19'h7FFFF, 8'hC3);
    idleSteps(6);

    $display("[TB] simultaneous requests from reset");
    resetDut();
    applyStimulus(1, 19'h00010, 1, 19'h00011, 8'h5C);
    checkOutput("simul_disp_first", obs_dg, 1);
    w_seen = 0;
    for (int i = 0; i < 10 && !w_seen; i++) begin
      applyStimulus(0, '0, 1, 19'h00011, 8'h5C);
      if (obs_wg === 1'b1) w_seen = 1;
    end
    checkOutput("simul_wr_follows", w_seen, 1);
    drainModel();

    $display("[TB] starvation bound");
    nd = 0; w_seen = 0; wait_i = 0;
    for (int i = 0; i < 40 && !w_seen; i++) begin
      applyStimulus(1, 19'(i), 1, 19'h00020, 8'h99);
      if (obs_dg === 1'b1) nd++;
      if (obs_wg === 1'b1) begin w_seen = 1; wait_i = i; end
    end
    checkOutput("starve_wr_granted", w_seen, 1);
    checkOutput("starve_disp_count", nd, SM);
    checkOutput("starve_wait_bound", (wait_i + 1) <= SM * (RD + 1) + 1, 1);
    d_seen = 0;
    for (int i = 0; i < 10 && !d_seen; i++) begin
      applyStimulus(1, 19'h00021, 0, '0, '0);
      if (obs_dg === 1'b1) d_seen = 1;
    end
    checkOutput("starve_disp_resumes", d_seen, 1);
    drainModel();

    $display("[TB] reset during write pulse");
    applyStimulus(0, '0, 1, 19'h00030, 8'hA5);
    applyStimulus(0, '0, 0, '0, '0);
    MemRst = 1'b1; DispReq = 0; WrReq = 0;
    #1;
    checkOutput("midrst_we_n",  MemWriteEnable, 1);
    checkOutput("midrst_drive", MemDataDrive, 0);
    checkOutput("midrst_busy",  Busy, 0);
    checkOutput("midrst_done",  WrDone, 0);
    #2;
    MemRst = 1'b0;
    modelReset();
    @(posedge MemClk);
    #1;
    cyc++;
    idleSteps(2);
    applyStimulus(1, 19'h00031, 0, '0, '0);
    idleSteps(4);

    $display("[TB] write wait statistic");
    resetDut();
    dr_pat = 19'b1111111_0000000_1_0000;
    wr_pat = 19'b1111111111_0000_1111_0;
    for (int i = 0; i < 19; i++)
      applyStimulus(dr_pat[i], 19'h00040, wr_pat[i], 19'h00041, 8'h3E);
    idleSteps(2);
    checkOutput("stats_waitmax", WaitMax, STATS ? 9 : 0);

    $display("[TB] random traffic");
    dr_lvl = 0; wr_lvl = 0; da = '0; wa = '0; wd = '0;
    for (int i = 0; i < 400; i++) begin
      if (dr_lvl) begin
        if ($urandom_range(0, 19) == 0) dr_lvl = 0;
      end else begin
        dr_lvl = ($urandom_range(0, 2) == 0);
        da = 19'($urandom_range(0, 15));
      end
      if (wr_lvl) begin
        if ($urandom_range(0, 29) == 0) wr_lvl = 0;
      end else begin
        wr_lvl = ($urandom_range(0, 3) == 0);
        wa = 19'($urandom_range(0, 15));
        wd = 8'($urandom);
      end
      applyStimulus(dr_lvl, da, wr_lvl, wa, wd);
      if (m_dg) begin dr_lvl = 1'($urandom_range(0, 1)); da = 19'($urandom_range(0, 15)); end
      if (m_wg) begin wr_lvl = 1'($urandom_range(0, 1)); wa = 19'($urandom_range(0, 15)); wd = 8'($urandom); end
    end
    drainModel();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
